// File: rtl/bcd_ss_disp_if.sv
// Bus bundle for bcd_ss_disp: sample request/value in, BCD, flags and
// seven-segment patterns out.
interface bcd_ss_disp_if;
  logic [7:0] IN;
  logic       STB;
  logic       BUSY;
  logic       DONE;
  logic       OVF;
  logic [7:0] BCD;
  logic [7:0] ss1;
  logic [7:0] ss0;

  modport master (
    output IN, STB,
    input  BUSY, DONE, OVF, BCD, ss1, ss0
  );

  modport slave (
    input  IN, STB,
    output BUSY, DONE, OVF, BCD, ss1, ss0
  );
endinterface

// File: rtl/bcd_ss_disp.sv
// Sequential double-dabble binary-to-BCD converter driving two seven-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks ss1 when the tens digit is zero.
module bcd_ss_disp (
  input  logic          CLK,
  input  logic          RST,
  bcd_ss_disp_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]  state;
  logic [7:0]  sreg;
  logic [11:0] acc;
  logic [2:0]  cnt;
  logic [11:0] acc_adj;
  logic        ovf_n;
  logic [7:0]  ss1_n;
  logic [7:0]  ss0_n;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Correction happens before the shift, so each nibble stays within 0..9 afterwards.
  assign acc_adj = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
  assign ovf_n   = (acc[11:8] != 4'd0);

  always_comb begin
    ss1_n = seg7(acc[7:4]);
    ss0_n = seg7(acc[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (acc[7:4] == 4'd0) ss1_n = 8'h00;
`endif
    if (ovf_n) begin
      ss1_n = 8'h40;
      ss0_n = 8'h40;
    end
  end

  assign bus.BUSY = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      sreg     <= 8'h00;
      acc      <= 12'h000;
      cnt      <= 3'd0;
      bus.DONE <= 1'b0;
      bus.OVF  <= 1'b0;
      bus.BCD  <= 8'h00;
      bus.ss1  <= 8'h00;
      bus.ss0  <= 8'h00;
    end else begin
      bus.DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.STB) begin
            sreg  <= bus.IN;
            acc   <= 12'h000;
            cnt   <= 3'd0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {acc, sreg} <= {acc_adj[10:0], sreg, 1'b0};
          cnt         <= cnt + 3'd1;
          if (cnt == 3'd7) state <= S_LOAD;
        end
        S_LOAD: begin
          bus.BCD  <= acc[7:0];
          bus.OVF  <= ovf_n;
          bus.ss1  <= ss1_n;
          bus.ss0  <= ss0_n;
          bus.DONE <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
